wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the CPU register file.
- Merges the single-cycle ALU result stream and the variable-latency load-return stream into the register file's single write port (we/rd/wd).
- Buffers load returns in a small FIFO and keeps a pending-load scoreboard that issue logic uses for hazard stalls.
- Outputs are registered so the register file sees clean write controls.

Parameters:
- LD_FIFO_DEPTH, 4, load-return FIFO entries; power of two, ≥2.
- XLEN, 32, data width; must match the register file.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  XLEN  ALU result.
- ld_valid  in  1  load return valid.
- ld_ready  out  1  load return accepted when ld_valid && ld_ready.
- ld_rd  in  5  load destination register.
- ld_wd  in  XLEN  load data.
- iss_valid  in  1  load issued this cycle; mark iss_rd pending.
- iss_rd  in  5  destination of the issued load.
- pend_mask  out  32  bit i = load to x i outstanding; bit 0 always 0.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wd  out  XLEN  register file write data.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - FIFO emptied; pend_mask=0.
  - rf_we=0, rf_rd=0, rf_wd=0; ld_ready=1.
  - Reset mid-operation discards all buffered loads and pending bits.
- Load handshake:
  - ld_ready = !fifo_full; it is a registered-state function and never depends on ld_valid.
  - Accept = ld_valid && ld_ready at posedge; {ld_rd, ld_wd} pushed.
  - ld_valid with ld_ready=0: the source holds; nothing is dropped.
- Arbitration, evaluated each cycle, result registered at posedge:
  - If alu_valid: rf_we<=(alu_rd!=0), rf_rd<=alu_rd, rf_wd<=alu_wd. The FIFO is not popped.
  - Else if FIFO non-empty: pop the head; rf_we<=(head.rd!=0), rf_rd<=head.rd, rf_wd<=head.wd.
  - Else rf_we<=0; rf_rd and rf_wd hold their previous values.
  - The ALU has strict priority. Upstream guarantees ALU bubbles, so load starvation is not handled here.
- Latency:
  - ALU value at edge N → rf_we high in cycle N..N+1 → register file written at edge N+1.
  - Load accepted at edge N into an empty FIFO with no ALU traffic → rf_we high after edge N+1 → register file written at edge N+2.
  - A load is never written in the same edge it is accepted; there is no FIFO fall-through.
- FIFO boundaries:
  - Push and pop in the same edge when full: the push is blocked anyway, because ld_ready was 0.
  - Push and pop in the same edge when not full: occupancy unchanged.
  - Pointers wrap modulo LD_FIFO_DEPTH, with an extra wrap bit for full/empty.
- Scoreboard:
  - pend_mask[i] set at posedge when iss_valid && iss_rd==i && i!=0.
  - Cleared at the posedge where a FIFO pop with head.rd==i is registered into rf_*.
  - Simultaneous set and clear of the same i: set wins.
  - iss_rd==0 is ignored.
- Protocol requirements, covered by bench assertions:
  - No iss_valid for a register whose pend_mask bit is already set.
  - No alu_valid to a pending register.
  - Every ld_rd corresponds to a pending bit.

Optional Feature:
- WB_BYPASS_EN: adds inputs byp_rs1[4:0], byp_rs2[4:0], rf_rd1[XLEN-1:0], rf_rd2[XLEN-1:0] and outputs byp_rd1, byp_rd2.
- With the macro: byp_rd1 = rf_wd if (rf_we && rf_rd==byp_rs1 && byp_rs1!=0), else rf_rd1. byp_rd2 is the same using rs2/rf_rd2. Both paths are purely combinational and hide the one-cycle register-file write-to-read gap.
- Without the macro: these ports do not exist. Decode must stall one cycle on a match.

Decomposition:
- Package wb_pkg: XLEN, REG_AW=5, typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] wd;}, and LD_FIFO_DEPTH default.
- One sub-module wb_fifo: synchronous FIFO of wb_req_t with push, pop, full, empty and head outputs.
- Arbitration, scoreboard and bypass stay in wb_arbiter.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_wd=32'hDEADBEEF for 1 cycle → rf_we=1, rf_rd=5, rf_wd=DEADBEEF exactly one cycle later, then rf_we=0.
- iss_rd=7, then load return ld_rd=7, ld_wd=32'h1234 with no ALU traffic → pend_mask[7]=1 until rf_we/rf_rd=7 is registered 2 edges after accept, then 0.
- 5 load returns back-to-back while alu_valid held high → ld_ready drops after 4 accepts. After alu_valid falls, 4 writes drain in FIFO order on consecutive cycles and ld_ready rises on the first pop.
- alu_rd=0 or ld_rd=0 → rf_we stays 0; pend_mask[0] never set.
- Reset asserted with 3 entries buffered and pend_mask=32'h0000_0380 → immediately pend_mask=0, rf_we=0, ld_ready=1; no stale write after release.
- WB_BYPASS_EN: rf_we=1, rf_rd=9, rf_wd=0xAA with byp_rs1=9, rf_rd1=0x55 → byp_rd1=0xAA. Same setup with byp_rs1=0 → byp_rd1=rf_rd1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_AW        = 5;
  localparam int unsigned LD_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  // One-hot of a destination register; x0 never produces a bit.
  function automatic logic [31:0] rd_onehot(logic [REG_AW-1:0] rd);
    logic [31:0] oh;
    oh = 32'd0;
    if (rd != '0) oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU/load sources, issue marks and register-file write port.
// Optional bypass read ports are present only when WB_BYPASS_EN is defined.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_wd;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_wd;
  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [31:0]       pend_mask;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wd;
`ifdef WB_BYPASS_EN
  logic [REG_AW-1:0] byp_rs1;
  logic [REG_AW-1:0] byp_rs2;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic [XLEN-1:0]   byp_rd1;
  logic [XLEN-1:0]   byp_rd2;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_wd, ld_valid, ld_rd, ld_wd, iss_valid, iss_rd,
    output ld_ready, pend_mask, rf_we, rf_rd, rf_wd
`ifdef WB_BYPASS_EN
    , input byp_rs1, byp_rs2, rf_rd1, rf_rd2,
    output byp_rd1, byp_rd2
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_wd, ld_valid, ld_rd, ld_wd, iss_valid, iss_rd,
    input  ld_ready, pend_mask, rf_we, rf_rd, rf_wd
`ifdef WB_BYPASS_EN
    , output byp_rs1, byp_rs2, rf_rd1, rf_rd2,
    input byp_rd1, byp_rd2
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of load returns; pointers carry an extra wrap bit for full/empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = LD_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  wb_req_t     mem_q [Depth];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take strict priority over buffered load returns into
// the register-file write port; tracks pending loads. Optional bypass: WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned LD_FIFO_DEPTH = wb_pkg::LD_FIFO_DEPTH
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  wb_req_t           head, push_data;
  logic              fifo_full, fifo_empty, push, pop;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_rd_q;
  logic [XLEN-1:0]   rf_wd_q;
  logic [31:0]       pend_q, pend_d;

  assign bus.ld_ready = !fifo_full;
  assign push         = bus.ld_valid && !fifo_full;
  assign pop          = !bus.alu_valid && !fifo_empty;
  assign push_data    = '{rd: bus.ld_rd, wd: bus.ld_wd};

  wb_fifo #(
    .Depth(LD_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else if (bus.alu_valid) begin
      rf_we_q <= (bus.alu_rd != '0);
      rf_rd_q <= bus.alu_rd;
      rf_wd_q <= bus.alu_wd;
    end else if (!fifo_empty) begin
      rf_we_q <= (head.rd != '0);
      rf_rd_q <= head.rd;
      rf_wd_q <= head.wd;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (pop)           pend_d = pend_d & ~rd_onehot(head.rd);
    if (bus.iss_valid) pend_d = pend_d | rd_onehot(bus.iss_rd);
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign bus.pend_mask = pend_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wd     = rf_wd_q;

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to decode reads, hiding the write-to-read gap.
  always_comb begin
    bus.byp_rd1 = bus.rf_rd1;
    bus.byp_rd2 = bus.rf_rd2;
    if (rf_we_q && (rf_rd_q == bus.byp_rs1) && (bus.byp_rs1 != '0)) bus.byp_rd1 = rf_wd_q;
    if (rf_we_q && (rf_rd_q == bus.byp_rs2) && (bus.byp_rs2 != '0)) bus.byp_rd2 = rf_wd_q;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write-order scoreboard and protocol checks.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  wb_req_t exp_q[$];

  wb_arbiter_if bus ();

  wb_arbiter #(
    .LD_FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rf_we === 1'b1) begin
      check("sb_write_expected", 32'(bus.rf_we), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("sb_rd", 32'(bus.rf_rd), 32'(e.rd));
        check("sb_wd", bus.rf_wd, e.wd);
      end
    end
  end

  // Stimulus protocol: no double issue, no ALU write or load return to a wrong register.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.iss_valid && bus.iss_rd != 0)
        check("proto_iss_not_pending", 32'(bus.pend_mask[bus.iss_rd]), 32'd0);
      if (bus.alu_valid && bus.alu_rd != 0)
        check("proto_alu_not_pending", 32'(bus.pend_mask[bus.alu_rd]), 32'd0);
      if (bus.ld_valid && bus.ld_ready && bus.ld_rd != 0)
        check("proto_ld_pending", 32'(bus.pend_mask[bus.ld_rd]), 32'd1);
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_wd    = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_wd     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
`ifdef WB_BYPASS_EN
    bus.byp_rs1   = '0;
    bus.byp_rs2   = '0;
    bus.rf_rd1    = '0;
    bus.rf_rd2    = '0;
`endif
    repeat (2) tick();
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    check("rst_rf_wd", bus.rf_wd, 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rst_pend", bus.pend_mask, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU write lands one edge later, for exactly one cycle.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_wd    = 32'hDEADBEEF;
    exp_q.push_back('{rd: 5'd5, wd: 32'hDEADBEEF});
    tick();
    bus.alu_valid = 1'b0;
    check("alu_we", 32'(bus.rf_we), 32'd1);
    check("alu_rd", 32'(bus.rf_rd), 32'd5);
    check("alu_wd", bus.rf_wd, 32'hDEADBEEF);
    tick();
    check("alu_we_drop", 32'(bus.rf_we), 32'd0);
    check("idle_rd_hold", 32'(bus.rf_rd), 32'd5);

    // Issue then return a load to x7.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    check("ld7_pend_set", bus.pend_mask, 32'h0000_0080);
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd7;
    bus.ld_wd    = 32'h1234;
    exp_q.push_back('{rd: 5'd7, wd: 32'h1234});
    tick();
    bus.ld_valid = 1'b0;
    check("ld7_no_fallthrough", 32'(bus.rf_we), 32'd0);
    check("ld7_pend_held", bus.pend_mask, 32'h0000_0080);
    tick();
    check("ld7_we", 32'(bus.rf_we), 32'd1);
    check("ld7_rd", 32'(bus.rf_rd), 32'd7);
    check("ld7_pend_clr", bus.pend_mask, 32'd0);
    tick();
    check("ld7_we_drop", 32'(bus.rf_we), 32'd0);

    // Fill the FIFO behind continuous ALU traffic to x0, then drain in order.
    for (int k = 0; k < 5; k++) begin
      bus.iss_valid = 1'b1;
      bus.iss_rd    = 5'(10 + k);
      tick();
    end
    bus.iss_valid = 1'b0;
    check("fill_pend", bus.pend_mask, 32'h0000_7C00);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_wd    = 32'hFFFF_0000;
    for (int k = 0; k < 4; k++) begin
      check("fill_ready", 32'(bus.ld_ready), 32'd1);
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'(10 + k);
      bus.ld_wd    = 32'hA000 + 32'(k);
      exp_q.push_back('{rd: 5'(10 + k), wd: 32'hA000 + 32'(k)});
      tick();
    end
    check("full_ready_low", 32'(bus.ld_ready), 32'd0);
    check("x0_alu_no_we", 32'(bus.rf_we), 32'd0);
    bus.ld_rd = 5'd14;
    bus.ld_wd = 32'hA004;
    tick();
    check("full_hold_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    tick();
    check("drain_ready_up", 32'(bus.ld_ready), 32'd1);
    check("drain_we0", 32'(bus.rf_we), 32'd1);
    check("drain_rd0", 32'(bus.rf_rd), 32'd10);
    exp_q.push_back('{rd: 5'd14, wd: 32'hA004});
    tick();
    bus.ld_valid = 1'b0;
    check("drain_rd1", 32'(bus.rf_rd), 32'd11);
    for (int j = 12; j < 15; j++) begin
      tick();
      check("drain_we", 32'(bus.rf_we), 32'd1);
      check("drain_rd", 32'(bus.rf_rd), 32'(j));
    end
    tick();
    check("drain_done_we", 32'(bus.rf_we), 32'd0);
    check("drain_pend", bus.pend_mask, 32'd0);

    // x0 destinations never write and never go pending.
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd0;
    bus.ld_wd    = 32'h0BAD;
    tick();
    bus.ld_valid = 1'b0;
    tick();
    check("x0_ld_no_we", 32'(bus.rf_we), 32'd0);
    check("x0_ld_popped", bus.rf_wd, 32'h0BAD);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    tick();
    bus.iss_valid = 1'b0;
    check("x0_iss_pend", bus.pend_mask, 32'd0);

    // Reset with three buffered loads discards everything.
    for (int k = 7; k < 10; k++) begin
      bus.iss_valid = 1'b1;
      bus.iss_rd    = 5'(k);
      tick();
    end
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    for (int k = 7; k < 10; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'(k);
      bus.ld_wd    = 32'hC000 + 32'(k);
      tick();
    end
    bus.ld_valid = 1'b0;
    check("pre_rst_pend", bus.pend_mask, 32'h0000_0380);
    check("pre_rst_ready", 32'(bus.ld_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pend", bus.pend_mask, 32'd0);
    check("mid_rst_we", 32'(bus.rf_we), 32'd0);
    check("mid_rst_ready", 32'(bus.ld_ready), 32'd1);
    bus.alu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_no_we", 32'(bus.rf_we), 32'd0);
    end
    check("post_rst_pend", bus.pend_mask, 32'd0);

`ifdef WB_BYPASS_EN
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_wd    = 32'hAA;
    exp_q.push_back('{rd: 5'd9, wd: 32'hAA});
    tick();
    bus.alu_valid = 1'b0;
    bus.byp_rs1   = 5'd9;
    bus.rf_rd1    = 32'h55;
    bus.byp_rs2   = 5'd3;
    bus.rf_rd2    = 32'h66;
    #1;
    check("byp1_hit", bus.byp_rd1, 32'hAA);
    check("byp2_miss", bus.byp_rd2, 32'h66);
    bus.byp_rs1 = 5'd0;
    bus.byp_rs2 = 5'd9;
    #1;
    check("byp1_x0", bus.byp_rd1, 32'h55);
    check("byp2_hit", bus.byp_rd2, 32'hAA);
    tick();
`endif

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
